fifo_access_arbiter: RTL and testbench
======================================

Name: fifo_access_arbiter

Overview:
- Controller that shares the single 8-entry operand FIFO between two requesters (m0, m1), each issuing one write or one read transaction at a time.
- Sequences the FIFO's one-cycle wr_en/rd_en strobes and collects the FIFO's wr_ack/wr_err/rd_ack/rd_err status.
- Returns a done/err/data response to the granted requester.
- Sits between the factorial datapath front-ends and the FIFO.

Parameters:
- DATA_WIDTH, 32, width of FIFO write/read data.
- TIMEOUT, 4, max cycles in WAIT with no FIFO status before forcing an error response (1..15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- m0_req  input  1  requester 0 transaction request; held high until m0_done.
- m0_wr  input  1  1 = write, 0 = read; sampled at grant.
- m0_din  input  DATA_WIDTH  write data; sampled at grant.
- m0_grant  output  1  high from grant cycle through response cycle.
- m0_done  output  1  one-cycle completion pulse.
- m0_err  output  1  high with m0_done when the transaction failed.
- m0_dout  output  DATA_WIDTH  read data; valid with m0_done on a successful read, holds until next m0 read.
- m1_req, m1_wr, m1_din, m1_grant, m1_done, m1_err, m1_dout: same as m0 for requester 1.
- f_wr_en  output  1  FIFO write strobe, one cycle.
- f_rd_en  output  1  FIFO read strobe, one cycle.
- f_din  output  DATA_WIDTH  FIFO write data.
- f_dout  input  DATA_WIDTH  FIFO read data.
- f_wr_ack, f_wr_err, f_rd_ack, f_rd_err  input  1 each  FIFO status flags.
- f_full, f_empty  input  1 each  FIFO flags; not used for gating; FIFO reports errors itself.

Behaviour:
- Reset (async, active-high) forces:
  - state = IDLE, all outputs 0, f_din = 0, m*_dout = 0.
  - timeout counter = 0, last-grant pointer = 1, so m0 wins the first conflict.
- Registered FSM, states IDLE, ISSUE, WAIT, RESP:
  - IDLE: if any req is high, pick the winner, latch wr/din into internal op/data registers, and assert the winner's grant on the next edge; go to ISSUE. Otherwise stay.
  - Arbitration is round-robin. With both req high, the winner is the requester not equal to last-grant. With one req high, that requester wins.
  - ISSUE: drive exactly one of f_wr_en (op = write, f_din = latched data) or f_rd_en (op = read) for one cycle. Clear the timeout counter. Go to WAIT.
  - WAIT: each cycle, sample the status flags:
    - f_wr_ack or f_rd_ack matching the op: success; capture f_dout on a read. Go to RESP.
    - f_wr_err or f_rd_err matching the op: failure. Go to RESP.
    - Neither: increment the counter. When it reaches TIMEOUT, fail and go to RESP.
    - Flags for the non-matching op are ignored.
  - RESP: pulse the winner's done for one cycle, with err = failure. Update the winner's dout only on a successful read. Set last-grant = winner, drop grant, return to IDLE.
- Latency: grant to done is 3 cycles minimum (grant visible in ISSUE; ack at earliest on the cycle after the strobe; done in RESP).
- Each transaction occupies at least 4 cycles including IDLE. No back-to-back bypass.
- Requester deasserting req after grant does not abort; the transaction completes and done still pulses.
- New requests are not sampled outside IDLE.
- Requester semantics: req high in the same cycle as its own done counts as a new request and is evaluated in the following IDLE cycle.
- Write to full FIFO: FIFO returns wr_err; response is done = 1, err = 1, and FIFO contents are unchanged.
- Read from empty FIFO: FIFO returns rd_err; response is done = 1, err = 1, and dout is unchanged.
- The non-granted requester's grant, done and err stay 0 for the whole transaction.
- f_wr_en and f_rd_en are never high together, and never high outside ISSUE.
- Reset asserted mid-transaction returns to IDLE immediately. No done is issued. A strobe already sent is not retracted.

Test Plan:
- Single write: m0_req = 1, m0_wr = 1, m0_din = 0x0000_0005, FIFO wr_ack on the cycle after the strobe -> f_wr_en is high one cycle with f_din = 5; m0_done = 1, m0_err = 0 exactly 3 cycles after m0_grant rises.
- Read success: FIFO holds 0x78, m1 read -> f_rd_en pulses once; rd_ack returned; m1_dout = 0x78 with m1_done, m1_err = 0.
- Simultaneous requests, both held for 3 transactions -> grant order m0, m1, m0; no overlap of grants; exactly one strobe per transaction.
- Write after 8 writes (full): FIFO returns wr_err -> m0_done = 1, m0_err = 1; a subsequent read returns the first-written data.
- Read from empty: rd_err -> m1_err = 1, m1_dout keeps its previous value. Separately, hold all status flags at 0 -> m0_done/m0_err pulse after TIMEOUT = 4 WAIT cycles.
- Reset asserted during WAIT -> all outputs 0 asynchronously; state IDLE; the next request is granted to m0 when both requesters are active.

Source files
------------

// File: rtl/fifo_access_arbiter.sv
// rtl/fifo_access_arbiter.sv - round-robin arbiter sharing one operand FIFO between two requesters
module fifo_access_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_wr,
  input  logic [DATA_WIDTH-1:0] m0_din,
  output logic                  m0_grant,
  output logic                  m0_done,
  output logic                  m0_err,
  output logic [DATA_WIDTH-1:0] m0_dout,
  input  logic                  m1_req,
  input  logic                  m1_wr,
  input  logic [DATA_WIDTH-1:0] m1_din,
  output logic                  m1_grant,
  output logic                  m1_done,
  output logic                  m1_err,
  output logic [DATA_WIDTH-1:0] m1_dout,
  output logic                  f_wr_en,
  output logic                  f_rd_en,
  output logic [DATA_WIDTH-1:0] f_din,
  input  logic [DATA_WIDTH-1:0] f_dout,
  input  logic                  f_wr_ack,
  input  logic                  f_wr_err,
  input  logic                  f_rd_ack,
  input  logic                  f_rd_err,
  input  logic                  f_full,
  input  logic                  f_empty
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // Last WAIT cycle index at which a silent FIFO forces an error response.
  localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

  state_t                  state_q;
  logic                    winner_q;
  logic                    last_q;
  logic                    op_wr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [3:0]              cnt_q;
  logic                    m0_grant_q, m1_grant_q;
  logic                    m0_done_q, m1_done_q;
  logic                    m0_err_q, m1_err_q;
  logic [DATA_WIDTH-1:0]   m0_dout_q, m1_dout_q;
  logic                    f_wr_en_q, f_rd_en_q;
  logic [DATA_WIDTH-1:0]   f_din_q;

  logic                    winner_d;
  logic                    hit_ack;
  logic                    hit_err;
  logic                    timed_out;

  // The FIFO reports its own overflow/underflow, so the level flags carry no decision here.
  logic                    unused_flags;
  assign unused_flags = f_full ^ f_empty;

  // Round-robin pick: on a conflict the requester not served last wins.
  always_comb begin
    winner_d = 1'b0;
    if (m0_req && m1_req) begin
      winner_d = ~last_q;
    end else if (m1_req) begin
      winner_d = 1'b1;
    end
  end

  // Status decode for the operation in flight; flags of the other operation are ignored.
  always_comb begin
    hit_ack   = op_wr_q ? f_wr_ack : f_rd_ack;
    hit_err   = op_wr_q ? f_wr_err : f_rd_err;
    timed_out = (cnt_q == TO_LAST);
  end

  // Transaction sequencer with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      winner_q   <= 1'b0;
      last_q     <= 1'b1;
      op_wr_q    <= 1'b0;
      data_q     <= '0;
      cnt_q      <= '0;
      m0_grant_q <= 1'b0;
      m1_grant_q <= 1'b0;
      m0_done_q  <= 1'b0;
      m1_done_q  <= 1'b0;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
      m0_dout_q  <= '0;
      m1_dout_q  <= '0;
      f_wr_en_q  <= 1'b0;
      f_rd_en_q  <= 1'b0;
      f_din_q    <= '0;
    end else begin
      f_wr_en_q <= 1'b0;
      f_rd_en_q <= 1'b0;
      m0_done_q <= 1'b0;
      m1_done_q <= 1'b0;
      m0_err_q  <= 1'b0;
      m1_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (m0_req || m1_req) begin
            winner_q   <= winner_d;
            op_wr_q    <= winner_d ? m1_wr : m0_wr;
            data_q     <= winner_d ? m1_din : m0_din;
            m0_grant_q <= ~winner_d;
            m1_grant_q <= winner_d;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          if (op_wr_q) begin
            f_wr_en_q <= 1'b1;
            f_din_q   <= data_q;
          end else begin
            f_rd_en_q <= 1'b1;
          end
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (hit_ack || hit_err || timed_out) begin
            if (winner_q) begin
              m1_done_q <= 1'b1;
              m1_err_q  <= ~hit_ack;
              if (hit_ack && !op_wr_q) m1_dout_q <= f_dout;
            end else begin
              m0_done_q <= 1'b1;
              m0_err_q  <= ~hit_ack;
              if (hit_ack && !op_wr_q) m0_dout_q <= f_dout;
            end
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        RESP: begin
          m0_grant_q <= 1'b0;
          m1_grant_q <= 1'b0;
          last_q     <= winner_q;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m0_grant = m0_grant_q;
  assign m1_grant = m1_grant_q;
  assign m0_done  = m0_done_q;
  assign m1_done  = m1_done_q;
  assign m0_err   = m0_err_q;
  assign m1_err   = m1_err_q;
  assign m0_dout  = m0_dout_q;
  assign m1_dout  = m1_dout_q;
  assign f_wr_en  = f_wr_en_q;
  assign f_rd_en  = f_rd_en_q;
  assign f_din    = f_din_q;

endmodule

// File: tb/tb_fifo_access_arbiter.sv
// tb/tb_fifo_access_arbiter.sv - scoreboard bench for fifo_access_arbiter
module tb_fifo_access_arbiter;

  localparam int DW    = 32;
  localparam int TB_TO = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          m0_req = 1'b0, m0_wr = 1'b0;
  logic [DW-1:0] m0_din = '0;
  logic          m1_req = 1'b0, m1_wr = 1'b0;
  logic [DW-1:0] m1_din = '0;
  logic          m0_grant, m0_done, m0_err, m1_grant, m1_done, m1_err;
  logic [DW-1:0] m0_dout, m1_dout;
  logic          f_wr_en, f_rd_en;
  logic [DW-1:0] f_din;
  logic [DW-1:0] f_dout = '0;
  logic          f_wr_ack = 1'b0, f_wr_err = 1'b0, f_rd_ack = 1'b0, f_rd_err = 1'b0;
  logic          f_full, f_empty;

  fifo_access_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(TB_TO)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_din(m0_din), .m0_grant(m0_grant),
    .m0_done(m0_done), .m0_err(m0_err), .m0_dout(m0_dout),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_din(m1_din), .m1_grant(m1_grant),
    .m1_done(m1_done), .m1_err(m1_err), .m1_dout(m1_dout),
    .f_wr_en(f_wr_en), .f_rd_en(f_rd_en), .f_din(f_din), .f_dout(f_dout),
    .f_wr_ack(f_wr_ack), .f_wr_err(f_wr_err), .f_rd_ack(f_rd_ack), .f_rd_err(f_rd_err),
    .f_full(f_full), .f_empty(f_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          who;
    bit          err;
    logic [DW-1:0] dout;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] rq[$];
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_dout [2];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            n_wr_str = 0;
  int            n_rd_str = 0;
  logic [DW-1:0] last_fdin = '0;
  bit            silent = 1'b0;

  logic          p_wr_ack = 1'b0, p_wr_err = 1'b0, p_rd_ack = 1'b0, p_rd_err = 1'b0;
  logic [DW-1:0] p_dout = '0;

  assign f_full  = (fq.size() >= 8);
  assign f_empty = (fq.size() == 0);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO model: strobe seen in cycle S, status visible for sampling at the end of cycle S+1.
  always @(negedge clk) begin
    f_wr_ack = p_wr_ack;
    f_wr_err = p_wr_err;
    f_rd_ack = p_rd_ack;
    f_rd_err = p_rd_err;
    if (p_rd_ack) f_dout = p_dout;
    p_wr_ack = 1'b0;
    p_wr_err = 1'b0;
    p_rd_ack = 1'b0;
    p_rd_err = 1'b0;
    if (!reset && !silent) begin
      if (f_wr_en) begin
        if (fq.size() < 8) begin
          fq.push_back(f_din);
          p_wr_ack = 1'b1;
        end else begin
          p_wr_err = 1'b1;
        end
      end
      if (f_rd_en) begin
        if (fq.size() > 0) begin
          p_dout   = fq.pop_front();
          p_rd_ack = 1'b1;
        end else begin
          p_rd_err = 1'b1;
        end
      end
    end
  end

  // Response monitor and protocol watch.
  always @(negedge clk) begin
    if (!reset) begin
      if (f_wr_en) begin
        n_wr_str++;
        last_fdin = f_din;
      end
      if (f_rd_en) n_rd_str++;
      if (f_wr_en && f_rd_en) check("strobe_overlap", 64'(1), 64'(0));
      if (m0_grant && m1_grant) check("grant_overlap", 64'(1), 64'(0));
      if ((m0_done && !m0_grant) || (m1_done && !m1_grant)) check("done_wo_grant", 64'(1), 64'(0));
      if (m0_done || m1_done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'(1), 64'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_who", 64'(m1_done), 64'(e.who));
          check("both_done", 64'(m0_done && m1_done), 64'(0));
          check("resp_err", 64'(e.who ? m1_err : m0_err), 64'(e.err));
          check("resp_dout", 64'(e.who ? m1_dout : m0_dout), 64'(e.dout));
        end
      end
    end
  end

  // Reference outcome of one transaction, pushed when it is requested.
  task automatic expect_txn(input bit who, input bit wr, input logic [DW-1:0] din);
    exp_t e;
    e.who = who;
    e.err = 1'b0;
    if (silent) begin
      e.err = 1'b1;
    end else if (wr) begin
      if (rq.size() < 8) rq.push_back(din);
      else e.err = 1'b1;
    end else begin
      if (rq.size() > 0) exp_dout[who] = rq.pop_front();
      else e.err = 1'b1;
    end
    e.dout = exp_dout[who];
    sb.push_back(e);
  endtask

  task automatic do_txn(input bit who, input bit wr, input logic [DW-1:0] din, input int exp_lat);
    int wr0, rd0, cyc, lat;
    wr0 = n_wr_str;
    rd0 = n_rd_str;
    expect_txn(who, wr, din);
    @(negedge clk);
    if (who) begin
      m1_req = 1'b1; m1_wr = wr; m1_din = din;
    end else begin
      m0_req = 1'b1; m0_wr = wr; m0_din = din;
    end
    cyc = 0;
    while (!(who ? m1_grant : m0_grant) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("grant_seen", 64'(cyc < 20), 64'(1));
    lat = 0;
    while (!(who ? m1_done : m0_done) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (who) m1_req = 1'b0;
    else m0_req = 1'b0;
    check("grant_to_done", 64'(lat), 64'(exp_lat));
    check("own_strobe", 64'(wr ? n_wr_str - wr0 : n_rd_str - rd0), 64'(1));
    check("other_strobe", 64'(wr ? n_rd_str - rd0 : n_wr_str - wr0), 64'(0));
    if (wr) check("f_din", 64'(last_fdin), 64'(din));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            nd, cyc, wr0;
    logic [2:0]    ord;
    int            nord;
    bit            p0, p1;

    exp_dout[0] = '0;
    exp_dout[1] = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ctrl", 64'({m0_grant, m0_done, m0_err, m1_grant, m1_done, m1_err, f_wr_en, f_rd_en}), 64'(0));
    check("rst_fdin", 64'(f_din), 64'(0));
    check("rst_dout", {m0_dout, m1_dout}, 64'(0));
    reset = 1'b0;

    // Single write, then reads.
    do_txn(1'b0, 1'b1, 32'h0000_0005, 3);
    do_txn(1'b1, 1'b0, 32'h0, 3);
    do_txn(1'b0, 1'b1, 32'h0000_0078, 3);
    do_txn(1'b1, 1'b0, 32'h0, 3);

    // Both requesters held for three transactions.
    expect_txn(1'b0, 1'b1, 32'hA1);
    expect_txn(1'b1, 1'b1, 32'hB2);
    expect_txn(1'b0, 1'b1, 32'hA1);
    wr0 = n_wr_str;
    @(negedge clk);
    m0_req = 1'b1; m0_wr = 1'b1; m0_din = 32'hA1;
    m1_req = 1'b1; m1_wr = 1'b1; m1_din = 32'hB2;
    nd = 0; cyc = 0; ord = '0; nord = 0; p0 = 1'b0; p1 = 1'b0;
    while (nd < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (m0_grant && !p0) begin ord = {ord[1:0], 1'b0}; nord++; end
      if (m1_grant && !p1) begin ord = {ord[1:0], 1'b1}; nord++; end
      p0 = m0_grant;
      p1 = m1_grant;
      if (m0_done || m1_done) nd++;
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    check("rr_dones", 64'(nd), 64'(3));
    check("rr_grants", 64'(nord), 64'(3));
    check("rr_order", 64'(ord), 64'(3'b010));
    check("rr_strobes", 64'(n_wr_str - wr0), 64'(3));

    // Fill to eight, overflow, then read back the oldest entry.
    for (int i = 0; i < 5; i++) do_txn(1'b0, 1'b1, 32'h100 + 32'(i), 3);
    do_txn(1'b0, 1'b1, 32'hDEAD, 3);
    do_txn(1'b1, 1'b0, 32'h0, 3);
    for (int i = 0; i < 7; i++) do_txn(1'(i % 2), 1'b0, 32'h0, 3);
    do_txn(1'b1, 1'b0, 32'h0, 3);

    // Silent FIFO: timeout path.
    silent = 1'b1;
    do_txn(1'b0, 1'b1, 32'h55, TB_TO + 1);
    do_txn(1'b1, 1'b0, 32'h0, TB_TO + 1);

    // Reset in the middle of WAIT.
    @(negedge clk);
    m0_req = 1'b1; m0_wr = 1'b1; m0_din = 32'h77;
    cyc = 0;
    while (!m0_grant && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_grant", 64'(m0_grant), 64'(1));
    @(negedge clk);
    @(negedge clk);
    check("mid_busy", 64'({m0_grant, m0_done}), 64'(2'b10));
    #1 reset = 1'b1;
    #1;
    check("async_rst_ctrl", 64'({m0_grant, m0_done, m0_err, m1_grant, m1_done, m1_err, f_wr_en, f_rd_en}), 64'(0));
    check("async_rst_fdin", 64'(f_din), 64'(0));
    check("async_rst_dout", {m0_dout, m1_dout}, 64'(0));
    m1_req = 1'b1; m1_wr = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_grant", 64'({m0_grant, m1_grant}), 64'(2'b10));
    reset = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    silent = 1'b0;
    @(negedge clk);

    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
